qos_class_tracker: RTL and testbench

//  Next-generation QoS flag block for the retry path: keeps a saturating pending-retry count and an
//  age counter per QoS class. Selects the class to retry next: highest class, with starvation escape
//  for aged classes. Exports a per-class pending flag vector as the successor of the one-hot type flag.

---
 rtl/qos_class_tracker_pkg.sv | 13 +
 rtl/qos_class_tracker_if.sv | 38 +++
 rtl/qos_class_tracker_cnt.sv | 57 +++++
 rtl/qos_class_tracker.sv | 94 +++++++++
 tb/tb_qos_class_tracker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qos_class_tracker_pkg.sv
// Shared QoS definitions for the retry-path blocks.
// Class count default, index width helper and class index type.
package qos_pkg;

  localparam int QOS_CLASS_TYPE_DFLT = 4;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [clog2_min1(QOS_CLASS_TYPE_DFLT)-1:0] qos_class_t;

endpackage

// File: rtl/qos_class_tracker_if.sv
// Push/pop handshake and status bundle of the QoS class tracker.
// The tracker sits on the slave side; the retry logic is the master.
interface qos_class_tracker_if
  import qos_pkg::*;
#(
  parameter int QOS_CLASS_TYPE = QOS_CLASS_TYPE_DFLT,
  parameter int CNT_W          = 4
);
  localparam int CW = clog2_min1(QOS_CLASS_TYPE);

  logic                            clean;
  logic                            push_vld;
  logic [CW-1:0]                   push_class;
  logic                            pop_vld;
  logic [QOS_CLASS_TYPE-1:0]       type_flag;
  logic [QOS_CLASS_TYPE-1:0]       full;
  logic [QOS_CLASS_TYPE*CNT_W-1:0] pend_cnt;
  logic                            sel_vld;
  logic [CW-1:0]                   sel_class;
  logic                            sel_starved;
  logic                            push_drop;
  logic                            pop_err;

  modport master (
    output clean, push_vld, push_class, pop_vld,
    input  type_flag, full, pend_cnt,
    input  sel_vld, sel_class, sel_starved,
    input  push_drop, pop_err
  );

  modport slave (
    input  clean, push_vld, push_class, pop_vld,
    output type_flag, full, pend_cnt,
    output sel_vld, sel_class, sel_starved,
    output push_drop, pop_err
  );

endinterface

// File: rtl/qos_class_tracker_cnt.sv
// Per-class saturating pending counter with age tracking.
// Same-cycle inc and dec cancel, so a full class accepts push+pop.
module qos_class_cnt #(
  parameter int CNT_W     = 4,
  parameter int AGE_W     = 4,
  parameter int AGE_LIMIT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clean,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             starved
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

  logic [CNT_W-1:0] count_d, count_q;
  logic [AGE_W-1:0] age_d, age_q;

  always_comb begin
    count_d = count_q;
    age_d   = age_q;
    if (clean) begin
      count_d = '0;
      age_d   = '0;
    end else begin
      if (inc && !dec && count_q != CNT_MAX)
        count_d = count_q + CNT_W'(1);
      else if (dec && !inc)
        count_d = count_q - CNT_W'(1);
      // a pop restarts the wait even if entries remain
      if (count_d == '0 || dec)
        age_d = '0;
      else if (age_q != AGE_MAX)
        age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      age_q   <= '0;
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  assign count   = count_q;
  assign full    = (count_q == CNT_MAX);
  assign starved = (count_q != '0) && (age_q >= AGE_LIM);

endmodule

// File: rtl/qos_class_tracker.sv
// Retry-path QoS tracker: per-class pending counts and ages,
// highest-class selection with lowest-index starvation escape.
module qos_class_tracker
  import qos_pkg::*;
#(
  parameter int QOS_CLASS_TYPE = QOS_CLASS_TYPE_DFLT,
  parameter int CNT_W          = 4,
  parameter int AGE_W          = 4,
  parameter int AGE_LIMIT      = 12
) (
  input logic                clk,
  input logic                rst_n,
  qos_class_tracker_if.slave bus
);
  localparam int N  = QOS_CLASS_TYPE;
  localparam int CW = clog2_min1(N);

  logic [N-1:0]     inc, dec, full, starved, pend;
  logic [CNT_W-1:0] cnt [N];
  logic [CW-1:0]    sel_class, hi_class, lo_class;
  logic             sel_vld, sel_starved;
  logic             push_drop_d, push_drop_q;
  logic             pop_err_d, pop_err_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_cls
    qos_class_cnt #(
      .CNT_W     (CNT_W),
      .AGE_W     (AGE_W),
      .AGE_LIMIT (AGE_LIMIT)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clean   (bus.clean),
      .inc     (inc[gi]),
      .dec     (dec[gi]),
      .count   (cnt[gi]),
      .full    (full[gi]),
      .starved (starved[gi])
    );
  end

  always_comb begin
    pend     = '0;
    hi_class = '0;
    lo_class = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = (cnt[i] != '0);
      if (pend[i]) hi_class = CW'(i);
    end
    for (int i = N - 1; i >= 0; i--)
      if (starved[i]) lo_class = CW'(i);
    sel_vld     = |pend;
    sel_starved = |starved;
    sel_class   = sel_starved ? lo_class : hi_class;
  end

  // out-of-range classes match no decoder bit and fall into the drop
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N; i++) begin
      inc[i] = bus.push_vld && (bus.push_class == CW'(i));
      dec[i] = bus.pop_vld && sel_vld && (sel_class == CW'(i));
    end
    push_drop_d = !bus.clean && bus.push_vld &&
                  !(|(inc & (~full | dec)));
    pop_err_d   = !bus.clean && bus.pop_vld && !sel_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_drop_q <= 1'b0;
      pop_err_q   <= 1'b0;
    end else begin
      push_drop_q <= push_drop_d;
      pop_err_q   <= pop_err_d;
    end
  end

  always_comb begin
    bus.pend_cnt = '0;
    for (int i = 0; i < N; i++)
      bus.pend_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign bus.type_flag   = pend;
  assign bus.full        = full;
  assign bus.sel_vld     = sel_vld;
  assign bus.sel_class   = sel_class;
  assign bus.sel_starved = sel_starved;
  assign bus.push_drop   = push_drop_q;
  assign bus.pop_err     = pop_err_q;

endmodule

// File: tb/tb_qos_class_tracker.sv
// Bench for qos_class_tracker: queue-count model checked every cycle
// plus directed scenarios with literal expectations.
module tb_qos_class_tracker;
  import qos_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int MAXC = 15;
  localparam int MAXA = 15;
  localparam int LIM  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qos_class_tracker_if #(.QOS_CLASS_TYPE(N), .CNT_W(4)) bus();

  qos_class_tracker #(
    .QOS_CLASS_TYPE (N),
    .CNT_W          (4),
    .AGE_W          (4),
    .AGE_LIMIT      (LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  int m_cnt [N];
  int m_age [N];
  bit m_drop, m_perr;

  function automatic int m_sel();
    for (int i = 0; i < N; i++)
      if (m_cnt[i] != 0 && m_age[i] >= LIM) return i;
    for (int i = N - 1; i >= 0; i--)
      if (m_cnt[i] != 0) return i;
    return -1;
  endfunction

  function automatic bit m_any_starved();
    for (int i = 0; i < N; i++)
      if (m_cnt[i] != 0 && m_age[i] >= LIM) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int nc [N];
    int na [N];
    int sc, pc;
    bit hon, nd;
    sc = m_sel();
    pc = int'(bus.push_class);
    hon = bus.pop_vld && (sc >= 0);
    nd = 1'b0;
    nc = m_cnt;
    na = m_age;
    if (bus.clean) begin
      for (int i = 0; i < N; i++) begin
        nc[i] = 0;
        na[i] = 0;
      end
    end else begin
      if (hon) nc[sc]--;
      if (bus.push_vld) begin
        if (pc >= N) nd = 1'b1;
        else if (hon && pc == sc) nc[pc]++;
        else if (m_cnt[pc] == MAXC) nd = 1'b1;
        else nc[pc]++;
      end
      for (int i = 0; i < N; i++)
        if (nc[i] == 0 || (hon && sc == i)) na[i] = 0;
        else na[i] = (m_age[i] < MAXA) ? m_age[i] + 1 : MAXA;
    end
    m_cnt  <= nc;
    m_age  <= na;
    m_drop <= !bus.clean && nd;
    m_perr <= !bus.clean && bus.pop_vld && (sc < 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 0;
        m_age[i] <= 0;
      end
      m_drop <= 1'b0;
      m_perr <= 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0]   tf, fl;
      logic [4*N-1:0] pc;
      int s;
      s = m_sel();
      for (int i = 0; i < N; i++) begin
        tf[i] = (m_cnt[i] != 0);
        fl[i] = (m_cnt[i] == MAXC);
        pc[i*4 +: 4] = 4'(m_cnt[i]);
      end
      chk("type_flag", 32'(bus.type_flag), 32'(tf));
      chk("full", 32'(bus.full), 32'(fl));
      chk("pend_cnt", 32'(bus.pend_cnt), 32'(pc));
      chk("sel_vld", 32'(bus.sel_vld), 32'(s >= 0));
      chk("sel_class", 32'(bus.sel_class), (s < 0) ? 32'd0 : 32'(s));
      chk("sel_starved", 32'(bus.sel_starved), 32'(m_any_starved()));
      chk("push_drop", 32'(bus.push_drop), 32'(m_drop));
      chk("pop_err", 32'(bus.pop_err), 32'(m_perr));
    end
  end

  task automatic cyc(input bit pv, input int pcl, input bit pp,
                     input bit cl);
    bus.push_vld   = pv;
    bus.push_class = CW'(pcl);
    bus.pop_vld    = pp;
    bus.clean      = cl;
    @(posedge clk);
    #1;
    bus.push_vld = 1'b0;
    bus.pop_vld  = 1'b0;
    bus.clean    = 1'b0;
  endtask

  function automatic logic [3:0] pend_of(input int c);
    logic [15:0] v;
    v = bus.pend_cnt;
    return v[c*4 +: 4];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clean      = 1'b0;
    bus.push_vld   = 1'b0;
    bus.push_class = '0;
    bus.pop_vld    = 1'b0;
    #12 rst_n = 1'b1;

    // idle after reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t1 type_flag", 32'(bus.type_flag), 32'h0);
    chk("t1 sel_vld", 32'(bus.sel_vld), 32'h0);
    chk("t1 push_drop", 32'(bus.push_drop), 32'h0);
    chk("t1 pop_err", 32'(bus.pop_err), 32'h0);

    // highest pending class wins
    cyc(1, 1, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 3, 0, 0);
    @(negedge clk);
    chk("t2 pend3", 32'(pend_of(3)), 32'd2);
    chk("t2 pend1", 32'(pend_of(1)), 32'd1);
    chk("t2 sel", 32'(bus.sel_class), 32'd3);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t2 sel after pops", 32'(bus.sel_class), 32'd1);
    chk("t2 type_flag", 32'(bus.type_flag), 32'h2);

    // saturation and drop
    cyc(0, 0, 0, 1);
    repeat (15) cyc(1, 2, 0, 0);
    @(negedge clk);
    chk("t3 full", 32'(bus.full), 32'h4);
    cyc(1, 2, 0, 0);
    @(negedge clk);
    chk("t3 drop", 32'(bus.push_drop), 32'h1);
    chk("t3 pend2", 32'(pend_of(2)), 32'd15);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("t3 drop gone", 32'(bus.push_drop), 32'h0);
    cyc(1, 2, 1, 0);
    @(negedge clk);
    chk("t3 pushpop pend2", 32'(pend_of(2)), 32'd15);
    chk("t3 pushpop drop", 32'(bus.push_drop), 32'h0);

    // starvation escape for class 0
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 3, 0, 0);
    for (int i = 0; i < 10; i++)
      if (i % 2 == 0) cyc(1, 3, 1, 0);
      else cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("t4 sel", 32'(bus.sel_class), 32'd0);
    chk("t4 starved", 32'(bus.sel_starved), 32'h1);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t4 sel after pop", 32'(bus.sel_class), 32'd3);
    chk("t4 starved after pop", 32'(bus.sel_starved), 32'h0);
    chk("t4 pend0", 32'(pend_of(0)), 32'd0);

    // clean beats push; pop on empty
    cyc(0, 0, 0, 1);
    repeat (5) cyc(1, 2, 0, 0);
    @(negedge clk);
    chk("t5 pend2", 32'(pend_of(2)), 32'd5);
    cyc(1, 2, 0, 1);
    @(negedge clk);
    chk("t5 pend all", 32'(bus.pend_cnt), 32'h0);
    chk("t5 drop", 32'(bus.push_drop), 32'h0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t5 pop_err", 32'(bus.pop_err), 32'h1);
    chk("t5 pend after err", 32'(bus.pend_cnt), 32'h0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("t5 pop_err gone", 32'(bus.pop_err), 32'h0);

    // async reset mid-burst
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    bus.push_vld   = 1'b1;
    bus.push_class = CW'(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 type_flag", 32'(bus.type_flag), 32'h0);
    chk("t6 pend", 32'(bus.pend_cnt), 32'h0);
    chk("t6 sel_vld", 32'(bus.sel_vld), 32'h0);
    chk("t6 sel_class", 32'(bus.sel_class), 32'h0);
    chk("t6 full", 32'(bus.full), 32'h0);
    @(posedge clk);
    #1;
    bus.push_vld = 1'b0;
    rst_n = 1'b1;
    cyc(1, 3, 0, 0);
    @(negedge clk);
    chk("t6 resume pend3", 32'(pend_of(3)), 32'd1);
    chk("t6 resume flag", 32'(bus.type_flag), 32'h8);
    chk("t6 resume sel", 32'(bus.sel_class), 32'd3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
